// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and counter sizing for the memory bus arbiter and its watchdog
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch port, data port and memory-side signals of the arbiter
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    i_req;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic [DATA_WIDTH-1:0]   i_rdata;
    logic                    i_ack;
    logic                    d_rd;
    logic                    d_wr;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH/8-1:0] d_wstrb;
    logic [DATA_WIDTH-1:0]   d_rdata;
    logic                    d_ack;
    logic                    mem_rd;
    logic                    mem_wr;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_ack;
    logic                    bus_err;

    modport slave (
        input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ack,
        output i_rdata, i_ack, d_rdata, d_ack, mem_rd, mem_wr, mem_addr, mem_wdata, mem_wstrb, bus_err
    );

    modport master (
        output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_rd, mem_wr, mem_addr, mem_wdata, mem_wstrb, bus_err
    );
endinterface

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts enabled cycles and flags the TIMEOUT_CYCLES-th one as expired
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = cnt_w(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    // cnt holds the number of enabled cycles already completed
    assign expired = en && cnt == LAST;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch and data ports,
// data first but bounded by a streak limit, with a watchdog abort.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);
    localparam int SW = cnt_w(MAX_D_STREAK);
    localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);

    state_t                state;
    owner_t                own;
    logic [SW-1:0]         streak;
    logic                  d_grant;
    logic                  wr_grant;
    logic                  busy;
    logic                  expired;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] rsp;

    assign d_grant  = (bus.d_rd || bus.d_wr) && !(bus.i_req && streak == SMAX);
    assign wr_grant = d_grant && bus.d_wr;
    assign gnt_addr = d_grant ? bus.d_addr : bus.i_addr;
    assign busy     = state == BUSY_I || state == BUSY_D;
    assign own      = state == BUSY_D ? OWN_D : OWN_I;
    assign rsp      = bus.mem_ack ? bus.mem_rdata : '0;

    arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk(clk),
        .reset(reset),
        .clr(!busy),
        .en(busy),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            streak        <= '0;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            bus.i_ack     <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.bus_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // only data grants made while a fetch waits count toward the streak
                    streak <= (bus.i_req && d_grant) ? (streak == SMAX ? streak : streak + 1'b1) : '0;
                    if (d_grant || bus.i_req) begin
                        state         <= d_grant ? BUSY_D : BUSY_I;
                        bus.mem_rd    <= !wr_grant;
                        bus.mem_wr    <= wr_grant;
                        bus.mem_addr  <= gnt_addr;
                        bus.mem_wdata <= wr_grant ? bus.d_wdata : '0;
                        bus.mem_wstrb <= wr_grant ? bus.d_wstrb : '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_ack || expired) begin
                        state       <= RESP;
                        bus.mem_rd  <= 1'b0;
                        bus.mem_wr  <= 1'b0;
                        bus.i_ack   <= own == OWN_I;
                        bus.d_ack   <= own == OWN_D;
                        bus.bus_err <= !bus.mem_ack;
                        if (own == OWN_I) bus.i_rdata <= rsp;
                        else bus.d_rdata <= rsp;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.i_ack   <= 1'b0;
                    bus.d_ack   <= 1'b0;
                    bus.bus_err <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one memory bus between the core's instruction-fetch port and data port, for cores with split I/D buses in front of the Controller's single main memory. Data accesses have fixed priority, bounded by a streak limit that guarantees fetch progress. One transaction is outstanding at a time, and a watchdog aborts a transaction when the memory never acknowledges it.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is pending (≥1)
- TIMEOUT_CYCLES, 255, number of cycles in BUSY without mem_ack before abort (≥2)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_WIDTH  fetch address
- i_rdata  out  DATA_WIDTH  fetch data, valid with i_ack
- i_ack  out  1  one-cycle fetch completion
- d_rd / d_wr  in  1 each  data read / write request, held until d_ack
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_wstrb  in  DATA_WIDTH/8  write byte enables
- d_rdata  out  DATA_WIDTH  read data, valid with d_ack
- d_ack  out  1  one-cycle data completion
- mem_rd / mem_wr  out  1 each  memory strobes, held until mem_ack
- mem_addr, mem_wdata, mem_wstrb  out  as above  registered memory request
- mem_rdata  in  DATA_WIDTH  memory read data, sampled with mem_ack
- mem_ack  in  1  memory completion
- bus_err  out  1  one-cycle pulse with i_ack/d_ack on timeout abort

## Operation
- States:
  - IDLE: samples requests.
  - BUSY_I / BUSY_D: memory strobes asserted.
  - RESP: ack to the owner.
- IDLE grant rule:
  - Data is granted if d_rd|d_wr and not (i_req and streak == MAX_D_STREAK).
  - Otherwise fetch is granted if i_req.
  - Otherwise stay in IDLE.
- d_rd and d_wr both high: treated as a write; mem_rd stays low.
- Fetch is always a read with mem_wstrb = 0; mem_wdata = 0 for reads.
- Streak counter:
  - +1 on each data grant, saturating at MAX_D_STREAK.
  - Cleared on a fetch grant, and on any IDLE cycle with i_req low.
- BUSY_x → RESP on mem_ack. mem_rdata is latched into the owner's rdata register; the other port's rdata is unchanged.
- Watchdog:
  - Counts cycles in BUSY_x.
  - At TIMEOUT_CYCLES without mem_ack: go to RESP, owner rdata = 0, bus_err = 1.
- RESP → IDLE unconditionally. Requesters must drop their request in the cycle after ack. A request still high in IDLE starts a new transaction.
- mem_ack outside BUSY_x is ignored.
- Reset (async, any state):
  - State = IDLE, streak = 0, watchdog = 0.
  - All outputs 0, including rdata registers.
  - Any in-flight transaction is dropped with no ack.

## Timing
- Cycle N: IDLE with a request.
- N+1: mem_* strobes/address/data valid (registered). They stay stable until the cycle mem_ack is seen.
- Memory acks in cycle M ≥ N+1.
  - M+1: RESP, x_ack = 1, x_rdata valid, mem strobes 0.
  - M+2: IDLE.
- Zero-wait memory: request-to-ack = 2 cycles, issue-to-issue = 3 cycles.
- Timeout: mem strobes high for exactly TIMEOUT_CYCLES cycles, then RESP with bus_err.
- No combinational path from any input to any output.

## Structure
- Package mem_arb_pkg:
  - State enum (IDLE, BUSY_I, BUSY_D, RESP).
  - Owner encoding (OWN_I, OWN_D).
  - Width helper for the streak and watchdog counters, $clog2(MAX+1).
- Sub-module arb_watchdog: counter with clear/enable inputs and an `expired` output at TIMEOUT_CYCLES. Reused by other bus bridges.
- Top module: FSM, streak counter, output registers.

## Test plan
- Fetch only, i_addr = 0x100, mem_ack in the first BUSY cycle, mem_rdata = 0x00000013 → mem_rd at N+1, i_ack with i_rdata = 0x13 at N+2, d_ack never set.
- d_wr at 0x2000, d_wdata = 0xDEADBEEF, d_wstrb = 0x3, 3-cycle ack delay → mem_wr high for 3 cycles with stable address/data/strb; mem_rd stays 0.
- i_req and d_rd held continuously, MAX_D_STREAK = 4 → grant sequence D,D,D,D,I,D,D,D,D,I.
- Memory never acks, TIMEOUT_CYCLES = 8 → mem_rd high for exactly 8 cycles, then d_ack = 1, bus_err = 1, d_rdata = 0; next transaction proceeds normally.
- d_rd and d_wr both high → only mem_wr asserted.
- reset driven low during BUSY_D → all outputs 0 immediately, no ack; after release, a held request is granted from IDLE.
